// File: rtl/cdecoder_scan_if.sv
// Bus bundle for cdecoder_scan.
//   master : drives select code, enable, mode, step and load strobes;
//            observes the decoded outputs.
//   slave  : the decoder side (inputs/outputs mirrored).
// Ports carried:
//   vstup  [N]     direct select code
//   en             output enable
//   mode   [2]     00 DIRECT, 01 SCAN_UP, 10 SCAN_DOWN, 11 HOLD
//   step           single-cycle advance strobe for scan modes
//   load           single-cycle strobe copying vstup into idx
//   vystup [2^N]   registered one-hot / one-cold decode of idx
//   idx    [N]     current registered select index
//   wrap           one-cycle pulse on index wrap-around
interface cdecoder_scan_if #(
    parameter int N = 3
);
    logic [N-1:0]        vstup;
    logic                en;
    logic [1:0]          mode;
    logic                step;
    logic                load;
    logic [(1<<N)-1:0]   vystup;
    logic [N-1:0]        idx;
    logic                wrap;

    modport master (
        output vstup, en, mode, step, load,
        input  vystup, idx, wrap
    );

    modport slave (
        input  vstup, en, mode, step, load,
        output vystup, idx, wrap
    );
endinterface

// File: rtl/cdecoder_scan.sv
// Registered N-to-2^N decoder with a scanning select index.
// The index is either taken straight from vstup (DIRECT), stepped up or down
// modulo 2^N on a step strobe (SCAN_UP / SCAN_DOWN), or frozen (HOLD).
// A load strobe overrides the mode and copies vstup into the index.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    cdecoder_scan_if slave modport (vstup, en, mode, step, load in;
//          vystup, idx, wrap out)
// Parameters:
//   N        select width, 1..6; output count is 2^N
//   ACT_LOW  1 inverts every output bit (one-cold decode)
//
// mode | meaning
// -----+--------------------------------------------------
//  00  | DIRECT    idx follows vstup every cycle
//  01  | SCAN_UP   idx+1 on step, wrap pulse on max->0
//  10  | SCAN_DOWN idx-1 on step, wrap pulse on 0->max
//  11  | HOLD      idx frozen
module cdecoder_scan #(
    parameter int N       = 3,
    parameter bit ACT_LOW = 1'b0
) (
    input logic         clk,
    input logic         rst_n,
    cdecoder_scan_if.slave bus
);
    localparam int OUTS = 1 << N;
    localparam logic [N-1:0] IDX_MAX = '1;

    typedef enum logic [1:0] {
        MODE_DIRECT    = 2'b00,
        MODE_SCAN_UP   = 2'b01,
        MODE_SCAN_DOWN = 2'b10,
        MODE_HOLD      = 2'b11
    } mode_t;

    logic [N-1:0]    idx_q;
    logic [N-1:0]    idx_nxt;
    logic            en_q;
    logic            wrap_q;
    logic            wrap_nxt;
    logic [OUTS-1:0] dec_nxt;
    logic [OUTS-1:0] vystup_q;
    mode_t           mode_s;

    assign mode_s = mode_t'(bus.mode);

    always_comb begin
        idx_nxt  = idx_q;
        wrap_nxt = 1'b0;
        if (bus.load) begin
            idx_nxt = bus.vstup;
        end else begin
            case (mode_s)
                MODE_DIRECT: idx_nxt = bus.vstup;
                MODE_SCAN_UP: begin
                    if (bus.step) begin
                        idx_nxt  = idx_q + 1'b1;
                        wrap_nxt = (idx_q == IDX_MAX);
                    end
                end
                MODE_SCAN_DOWN: begin
                    if (bus.step) begin
                        idx_nxt  = idx_q - 1'b1;
                        wrap_nxt = (idx_q == '0);
                    end
                end
                default: idx_nxt = idx_q;
            endcase
        end
    end

    // Decode from the next-state index and the enable being registered this
    // edge, so vystup always agrees with idx in the same cycle.
    always_comb begin
        dec_nxt = '0;
        if (bus.en) begin
            dec_nxt[idx_nxt] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            en_q     <= 1'b0;
            wrap_q   <= 1'b0;
            vystup_q <= {OUTS{ACT_LOW}};
        end else begin
            idx_q    <= idx_nxt;
            en_q     <= bus.en;
            wrap_q   <= wrap_nxt;
            vystup_q <= ACT_LOW ? ~dec_nxt : dec_nxt;
        end
    end

    assign bus.vystup = vystup_q;
    assign bus.idx    = idx_q;
    assign bus.wrap   = wrap_q;

    // en_q is the architectural enable state; its value is already folded
    // into vystup_q, so it has no other reader.
    logic unused_en;
    assign unused_en = en_q;
endmodule

// File: tb/tb_cdecoder_scan.sv
module tb_cdecoder_scan;
    logic clk;
    logic rst_n;

    cdecoder_scan_if #(.N(3)) d3 ();
    cdecoder_scan_if #(.N(2)) d2 ();
    cdecoder_scan_if #(.N(1)) d1 ();

    cdecoder_scan #(.N(3), .ACT_LOW(1'b0)) u_d3 (.clk(clk), .rst_n(rst_n), .bus(d3.slave));
    cdecoder_scan #(.N(2), .ACT_LOW(1'b1)) u_d2 (.clk(clk), .rst_n(rst_n), .bus(d2.slave));
    cdecoder_scan #(.N(1), .ACT_LOW(1'b0)) u_d1 (.clk(clk), .rst_n(rst_n), .bus(d1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {idx, wrap, vystup} expectations for each instance
    logic [11:0] sb3[$];
    logic [6:0]  sb2[$];
    logic [3:0]  sb1[$];

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [2:0] vstup;
        logic       en;
        logic [1:0] mode;
        logic       step;
        logic       load;
        logic [2:0] e_idx;
        logic       e_wrap;
        logic [7:0] e_vys;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply3(input vec_t v);
        d3.vstup = v.vstup;
        d3.en    = v.en;
        d3.mode  = v.mode;
        d3.step  = v.step;
        d3.load  = v.load;
        sb3.push_back({v.e_idx, v.e_wrap, v.e_vys});
    endtask

    task automatic test_reset();
        logic [11:0] e3;
        logic [6:0]  e2;
        logic [3:0]  e1;
        sb3.push_back({3'd0, 1'b0, 8'h00});
        sb2.push_back({2'd0, 1'b0, 4'hF});
        sb1.push_back({1'd0, 1'b0, 2'b00});
        e3 = sb3.pop_front();
        e2 = sb2.pop_front();
        e1 = sb1.pop_front();
        n_cmp += 3;
        if ({d3.idx, d3.wrap, d3.vystup} !== e3) begin
            n_fail++;
            $display("FAIL reset_n3: got %h want %h", {d3.idx, d3.wrap, d3.vystup}, e3);
        end
        if ({d2.idx, d2.wrap, d2.vystup} !== e2) begin
            n_fail++;
            $display("FAIL reset_n2_actlow: got %h want %h", {d2.idx, d2.wrap, d2.vystup}, e2);
        end
        if ({d1.idx, d1.wrap, d1.vystup} !== e1) begin
            n_fail++;
            $display("FAIL reset_n1: got %h want %h", {d1.idx, d1.wrap, d1.vystup}, e1);
        end
    endtask

    task automatic test_direct();
        vec_t tbl [4];
        logic [11:0] e;
        tbl = '{'{3'd5, 1'b1, 2'b00, 1'b0, 1'b0, 3'd5, 1'b0, 8'h20},
                '{3'd2, 1'b1, 2'b00, 1'b1, 1'b0, 3'd2, 1'b0, 8'h04},
                '{3'd7, 1'b1, 2'b00, 1'b0, 1'b0, 3'd7, 1'b0, 8'h80},
                '{3'd0, 1'b1, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0, 8'h01}};
        foreach (tbl[i]) begin
            apply3(tbl[i]);
            tick();
            e = sb3.pop_front();
            n_cmp++;
            if ({d3.idx, d3.wrap, d3.vystup} !== e) begin
                n_fail++;
                $display("FAIL direct[%0d]: got idx=%0d wrap=%0b vystup=%h want idx=%0d wrap=%0b vystup=%h",
                         i, d3.idx, d3.wrap, d3.vystup, e[11:9], e[8], e[7:0]);
            end
        end
    endtask

    task automatic test_scan_up();
        vec_t tbl [4];
        logic [11:0] e;
        tbl = '{'{3'd6, 1'b1, 2'b01, 1'b0, 1'b1, 3'd6, 1'b0, 8'h40},
                '{3'd0, 1'b1, 2'b01, 1'b1, 1'b0, 3'd7, 1'b0, 8'h80},
                '{3'd0, 1'b1, 2'b01, 1'b1, 1'b0, 3'd0, 1'b1, 8'h01},
                '{3'd5, 1'b1, 2'b01, 1'b0, 1'b0, 3'd0, 1'b0, 8'h01}};
        foreach (tbl[i]) begin
            apply3(tbl[i]);
            tick();
            e = sb3.pop_front();
            n_cmp++;
            if ({d3.idx, d3.wrap, d3.vystup} !== e) begin
                n_fail++;
                $display("FAIL scan_up[%0d]: got idx=%0d wrap=%0b vystup=%h want idx=%0d wrap=%0b vystup=%h",
                         i, d3.idx, d3.wrap, d3.vystup, e[11:9], e[8], e[7:0]);
            end
        end
    endtask

    task automatic test_scan_down();
        vec_t tbl [4];
        logic [11:0] e;
        tbl = '{'{3'd0, 1'b1, 2'b10, 1'b0, 1'b1, 3'd0, 1'b0, 8'h01},
                '{3'd3, 1'b1, 2'b10, 1'b1, 1'b0, 3'd7, 1'b1, 8'h80},
                '{3'd3, 1'b1, 2'b10, 1'b0, 1'b0, 3'd7, 1'b0, 8'h80},
                '{3'd3, 1'b1, 2'b10, 1'b1, 1'b0, 3'd6, 1'b0, 8'h40}};
        foreach (tbl[i]) begin
            apply3(tbl[i]);
            tick();
            e = sb3.pop_front();
            n_cmp++;
            if ({d3.idx, d3.wrap, d3.vystup} !== e) begin
                n_fail++;
                $display("FAIL scan_down[%0d]: got idx=%0d wrap=%0b vystup=%h want idx=%0d wrap=%0b vystup=%h",
                         i, d3.idx, d3.wrap, d3.vystup, e[11:9], e[8], e[7:0]);
            end
        end
    endtask

    task automatic test_load_priority();
        vec_t tbl [3];
        logic [11:0] e;
        tbl = '{'{3'd7, 1'b1, 2'b01, 1'b0, 1'b1, 3'd7, 1'b0, 8'h80},
                '{3'd3, 1'b1, 2'b01, 1'b1, 1'b1, 3'd3, 1'b0, 8'h08},
                '{3'd0, 1'b1, 2'b10, 1'b1, 1'b1, 3'd0, 1'b0, 8'h01}};
        foreach (tbl[i]) begin
            apply3(tbl[i]);
            tick();
            e = sb3.pop_front();
            n_cmp++;
            if ({d3.idx, d3.wrap, d3.vystup} !== e) begin
                n_fail++;
                $display("FAIL load_priority[%0d]: got idx=%0d wrap=%0b vystup=%h want idx=%0d wrap=%0b vystup=%h",
                         i, d3.idx, d3.wrap, d3.vystup, e[11:9], e[8], e[7:0]);
            end
        end
    endtask

    task automatic test_en_gate();
        vec_t tbl [5];
        logic [11:0] e;
        tbl = '{'{3'd1, 1'b1, 2'b01, 1'b0, 1'b1, 3'd1, 1'b0, 8'h02},
                '{3'd0, 1'b0, 2'b01, 1'b1, 1'b0, 3'd2, 1'b0, 8'h00},
                '{3'd0, 1'b0, 2'b01, 1'b1, 1'b0, 3'd3, 1'b0, 8'h00},
                '{3'd0, 1'b0, 2'b01, 1'b1, 1'b0, 3'd4, 1'b0, 8'h00},
                '{3'd0, 1'b1, 2'b01, 1'b0, 1'b0, 3'd4, 1'b0, 8'h10}};
        foreach (tbl[i]) begin
            apply3(tbl[i]);
            tick();
            e = sb3.pop_front();
            n_cmp++;
            if ({d3.idx, d3.wrap, d3.vystup} !== e) begin
                n_fail++;
                $display("FAIL en_gate[%0d]: got idx=%0d wrap=%0b vystup=%h want idx=%0d wrap=%0b vystup=%h",
                         i, d3.idx, d3.wrap, d3.vystup, e[11:9], e[8], e[7:0]);
            end
        end
    endtask

    task automatic test_hold();
        vec_t tbl [2];
        logic [11:0] e;
        tbl = '{'{3'd0, 1'b1, 2'b11, 1'b1, 1'b0, 3'd4, 1'b0, 8'h10},
                '{3'd7, 1'b1, 2'b11, 1'b0, 1'b0, 3'd4, 1'b0, 8'h10}};
        foreach (tbl[i]) begin
            apply3(tbl[i]);
            tick();
            e = sb3.pop_front();
            n_cmp++;
            if ({d3.idx, d3.wrap, d3.vystup} !== e) begin
                n_fail++;
                $display("FAIL hold[%0d]: got idx=%0d wrap=%0b vystup=%h want idx=%0d wrap=%0b vystup=%h",
                         i, d3.idx, d3.wrap, d3.vystup, e[11:9], e[8], e[7:0]);
            end
        end
    endtask

    // Random traffic checked against a small behavioural model.
    task automatic test_random();
        logic [2:0]  m_idx;
        logic [2:0]  n_idx;
        logic        n_wrap;
        logic [7:0]  n_vys;
        logic [11:0] e;
        vec_t        v;
        m_idx = 3'd0;
        for (int i = 0; i < 200; i++) begin
            v.vstup = 3'($urandom_range(0, 7));
            v.en    = ($urandom_range(0, 3) != 0);
            v.mode  = 2'($urandom_range(0, 3));
            v.step  = ($urandom_range(0, 1) == 1);
            v.load  = (i == 0) || ($urandom_range(0, 7) == 0);
            if (i == 0) v.vstup = 3'd0;
            n_idx  = m_idx;
            n_wrap = 1'b0;
            if (v.load) begin
                n_idx = v.vstup;
            end else if (v.mode == 2'b00) begin
                n_idx = v.vstup;
            end else if (v.mode == 2'b01 && v.step) begin
                n_wrap = (m_idx == 3'd7);
                n_idx  = (m_idx == 3'd7) ? 3'd0 : m_idx + 3'd1;
            end else if (v.mode == 2'b10 && v.step) begin
                n_wrap = (m_idx == 3'd0);
                n_idx  = (m_idx == 3'd0) ? 3'd7 : m_idx - 3'd1;
            end
            n_vys    = v.en ? (8'h01 << n_idx) : 8'h00;
            m_idx    = n_idx;
            v.e_idx  = n_idx;
            v.e_wrap = n_wrap;
            v.e_vys  = n_vys;
            apply3(v);
            tick();
            e = sb3.pop_front();
            n_cmp++;
            if ({d3.idx, d3.wrap, d3.vystup} !== e) begin
                n_fail++;
                $display("FAIL random[%0d]: got idx=%0d wrap=%0b vystup=%h want idx=%0d wrap=%0b vystup=%h",
                         i, d3.idx, d3.wrap, d3.vystup, e[11:9], e[8], e[7:0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] e3;
        logic [6:0]  e2;
        d2.en = 1'b1; d2.mode = 2'b01; d2.step = 1'b1; d2.load = 1'b0; d2.vstup = 2'd0;
        d3.en = 1'b1; d3.mode = 2'b01; d3.step = 1'b1; d3.load = 1'b0; d3.vstup = 3'd0;
        sb2.push_back({2'd1, 1'b0, 4'hD});
        sb2.push_back({2'd2, 1'b0, 4'hB});
        for (int i = 0; i < 2; i++) begin
            tick();
            e2 = sb2.pop_front();
            n_cmp++;
            if ({d2.idx, d2.wrap, d2.vystup} !== e2) begin
                n_fail++;
                $display("FAIL pre_reset_n2[%0d]: got %h want %h", i, {d2.idx, d2.wrap, d2.vystup}, e2);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        sb3.push_back({3'd0, 1'b0, 8'h00});
        sb2.push_back({2'd0, 1'b0, 4'hF});
        e3 = sb3.pop_front();
        e2 = sb2.pop_front();
        n_cmp += 2;
        if ({d3.idx, d3.wrap, d3.vystup} !== e3) begin
            n_fail++;
            $display("FAIL async_reset_n3: got %h want %h", {d3.idx, d3.wrap, d3.vystup}, e3);
        end
        if ({d2.idx, d2.wrap, d2.vystup} !== e2) begin
            n_fail++;
            $display("FAIL async_reset_n2: got %h want %h", {d2.idx, d2.wrap, d2.vystup}, e2);
        end
        tick();
        rst_n = 1'b1;
        d2.step = 1'b0;
        sb3.push_back({3'd1, 1'b0, 8'h02});
        sb2.push_back({2'd0, 1'b0, 4'hE});
        tick();
        e3 = sb3.pop_front();
        e2 = sb2.pop_front();
        n_cmp += 2;
        if ({d3.idx, d3.wrap, d3.vystup} !== e3) begin
            n_fail++;
            $display("FAIL post_reset_n3: got %h want %h", {d3.idx, d3.wrap, d3.vystup}, e3);
        end
        if ({d2.idx, d2.wrap, d2.vystup} !== e2) begin
            n_fail++;
            $display("FAIL post_reset_n2: got %h want %h", {d2.idx, d2.wrap, d2.vystup}, e2);
        end
        d2.mode = 2'b11;
    endtask

    task automatic test_n1();
        logic [3:0] e1;
        logic [1:0] modes [3];
        modes = '{2'b10, 2'b01, 2'b10};
        sb1.push_back({1'd1, 1'b1, 2'b10});
        sb1.push_back({1'd0, 1'b1, 2'b01});
        sb1.push_back({1'd1, 1'b1, 2'b10});
        d1.en = 1'b1; d1.step = 1'b1; d1.load = 1'b0; d1.vstup = 1'b0;
        foreach (modes[i]) begin
            d1.mode = modes[i];
            tick();
            e1 = sb1.pop_front();
            n_cmp++;
            if ({d1.idx, d1.wrap, d1.vystup} !== e1) begin
                n_fail++;
                $display("FAIL n1_step[%0d]: got %h want %h", i, {d1.idx, d1.wrap, d1.vystup}, e1);
            end
        end
        d1.step = 1'b0;
        sb1.push_back({1'd1, 1'b0, 2'b10});
        tick();
        e1 = sb1.pop_front();
        n_cmp++;
        if ({d1.idx, d1.wrap, d1.vystup} !== e1) begin
            n_fail++;
            $display("FAIL n1_idle: got %h want %h", {d1.idx, d1.wrap, d1.vystup}, e1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        d3.vstup = '0; d3.en = 1'b0; d3.mode = 2'b11; d3.step = 1'b0; d3.load = 1'b0;
        d2.vstup = '0; d2.en = 1'b0; d2.mode = 2'b11; d2.step = 1'b0; d2.load = 1'b0;
        d1.vstup = '0; d1.en = 1'b0; d1.mode = 2'b11; d1.step = 1'b0; d1.load = 1'b0;
        tick();
        tick();
        test_reset();
        rst_n = 1'b1;
        test_direct();
        test_scan_up();
        test_scan_down();
        test_load_priority();
        test_en_gate();
        test_hold();
        test_random();
        test_reset_mid();
        test_n1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
